// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int CLK_DIV_DEFAULT = 2;
  localparam int SPI_BITS        = 8;

endpackage : spi_pkg

// File: rtl/spi_byte_master_clk_gen.sv
// SPI clock divider: toggles sclk every CLK_DIV clk cycles while enabled and
// flags the clk edge on which sclk will rise or fall.
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] div_cnt;
  logic          tick;

  assign tick = en && (div_cnt == CW'(CLK_DIV - 1));
  assign rise = tick && !sclk;
  assign fall = tick &&  sclk;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      sclk    <= !sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule : spi_clk_gen

// File: rtl/spi_byte_master.sv
// Mode-0 SPI master moving one byte per start request, MSB first.
// Define SPI_BURST_EN to let a start in FINISH chain bytes into one cs frame.
module spi_byte_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       buzy,
  output logic       done,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       cs,
  output logic       mosi,
  input  logic       miso,
  output logic       sclk
);

  state_t     state, state_next;
  logic [7:0] tx_sr, rx_sr;
  logic [3:0] bit_cnt;
  logic       cs_next, buzy_next, done_next;
  logic       load, capture;
  logic       sclk_rise, sclk_fall;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk   (clk),
    .reset (reset),
    .en    (state == SHIFT),
    .sclk  (sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  assign mosi = (state == SHIFT) && tx_sr[7];

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cs_next    = cs;
    buzy_next  = buzy;
    done_next  = 1'b0;
    load       = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        cs_next   = 1'b1;
        buzy_next = 1'b0;
        if (start) begin
          state_next = SHIFT;
          cs_next    = 1'b0;
          buzy_next  = 1'b1;
          load       = 1'b1;
        end
      end
      SHIFT: begin
        if (sclk_fall && bit_cnt == 4'(SPI_BITS - 1)) begin
          state_next = FINISH;
          capture    = 1'b1;
          done_next  = 1'b1;
`ifndef SPI_BURST_EN
          cs_next    = 1'b1;
          buzy_next  = 1'b0;
`endif
        end
      end
      FINISH: begin
        state_next = IDLE;
`ifdef SPI_BURST_EN
        // Frame stays open while the host keeps chaining bytes.
        if (start) begin
          state_next = SHIFT;
          load       = 1'b1;
        end else begin
          cs_next    = 1'b1;
          buzy_next  = 1'b0;
        end
`endif
      end
      default: begin
        state_next = IDLE;
        cs_next    = 1'b1;
        buzy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cs    <= 1'b1;
      buzy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cs    <= cs_next;
      buzy  <= buzy_next;
      done  <= done_next;
    end
  end

  // NOTE: the shift registers are reset too, so a transfer aborted by reset
  // cannot leak stale bits into mosi or a later data_out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      data_out <= '0;
    end else begin
      if (load) begin
        tx_sr   <= data_in;
        bit_cnt <= '0;
      end else if (sclk_fall) begin
        tx_sr   <= {tx_sr[6:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (sclk_rise) rx_sr <= {rx_sr[6:0], miso};
      if (capture)   data_out <= rx_sr;
    end
  end

endmodule : spi_byte_master

// File: tb/tb_spi_byte_master.sv
// Self-checking bench: CLK_DIV=2 directed tests plus a CLK_DIV=1 48-byte run,
// each against a simple mode-0 slave model and an expected-byte scoreboard.
module tb_spi_byte_master;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // CLK_DIV=2 instance
  logic       s2_start = 1'b0, s2_buzy, s2_done, s2_cs, s2_mosi, s2_miso, s2_sclk;
  logic [7:0] s2_din = '0, s2_dout;
  logic [7:0] s2_byte = '0;
  logic       s2_loop = 1'b0;
  logic [3:0] s2_idx = '0;

  // CLK_DIV=1 instance
  logic       s1_start = 1'b0, s1_buzy, s1_done, s1_cs, s1_mosi, s1_miso, s1_sclk;
  logic [7:0] s1_din = '0, s1_dout;
  logic [7:0] s1_byte = '0;
  logic [3:0] s1_idx = '0;

  spi_byte_master #(.CLK_DIV(2)) dut2 (
    .clk(clk), .reset(reset), .start(s2_start), .buzy(s2_buzy), .done(s2_done),
    .data_in(s2_din), .data_out(s2_dout), .cs(s2_cs), .mosi(s2_mosi),
    .miso(s2_miso), .sclk(s2_sclk)
  );

  spi_byte_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(s1_start), .buzy(s1_buzy), .done(s1_done),
    .data_in(s1_din), .data_out(s1_dout), .cs(s1_cs), .mosi(s1_mosi),
    .miso(s1_miso), .sclk(s1_sclk)
  );

  // Mode-0 slaves: bit 7 valid while cs is low, next bit after each sclk fall.
  always @(negedge s2_sclk or posedge s2_cs)
    if (s2_cs) s2_idx <= '0; else s2_idx <= s2_idx + 1'b1;
  always @(negedge s1_sclk or posedge s1_cs)
    if (s1_cs) s1_idx <= '0; else s1_idx <= s1_idx + 1'b1;

  assign s2_miso = s2_loop ? s2_mosi : s2_byte[3'd7 - s2_idx[2:0]];
  assign s1_miso = s1_byte[3'd7 - s1_idx[2:0]];

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop_check(input string tag, input logic [7:0] obs);
    if (exp_q.size() == 0) check({tag, "_unexpected_done"}, 32'd1, 32'd0);
    else                   check(tag, {24'd0, obs}, {24'd0, exp_q.pop_front()});
  endtask

  // One CLK_DIV=2 byte; k counts clk edges after the accepting edge E0.
  task automatic run_byte2(input logic [7:0] din, input logic [7:0] slv, input bit loop,
                           input bit poke, output int lat, output int cs_low,
                           output logic [7:0] mbits, output int ndone);
    int   k;
    logic prev;
    exp_q.push_back(loop ? din : slv);
    s2_byte = slv;
    s2_loop = loop;
    @(negedge clk);
    s2_din   = din;
    s2_start = 1'b1;
    @(posedge clk); #1;
    s2_start = 1'b0;
    k = 0; lat = -1; ndone = 0; mbits = '0;
    cs_low = (s2_cs == 1'b0) ? 1 : 0;
    prev = s2_sclk;
    while (k < 120 && (lat < 0 || k < lat + 40)) begin
      @(posedge clk); #1;
      k++;
      if (poke && k == 5) begin
        s2_start = 1'b1;
        s2_din   = ~din;
      end else begin
        s2_start = 1'b0;
      end
      if (!s2_cs) cs_low++;
      if (s2_sclk && !prev) mbits = {mbits[6:0], s2_mosi};
      prev = s2_sclk;
      if (s2_done) begin
        ndone++;
        if (lat < 0) lat = k;
        sb_pop_check("data_out", s2_dout);
      end
    end
  endtask

`ifdef SPI_BURST_EN
  localparam int CS_LOW_1B = 33;
  localparam int HELD_GAP  = 33;
  localparam int D1_GAP    = 17;
  localparam int D1_FRAMES = 1;
`else
  localparam int CS_LOW_1B = 32;
  localparam int HELD_GAP  = 34;
  localparam int D1_GAP    = 18;
  localparam int D1_FRAMES = 48;
`endif

  initial begin
    int         lat, cs_low, ndone, k, dn, hold, issued, frames, last_k, bad_gap;
    int         held_k[3];
    logic       prev_cs;
    logic [7:0] mbits, rb;

    // Reset values
    #12;
    check("rst_cs",   s2_cs,   1'b1);
    check("rst_sclk", s2_sclk, 1'b0);
    check("rst_mosi", s2_mosi, 1'b0);
    check("rst_buzy", s2_buzy, 1'b0);
    check("rst_done", s2_done, 1'b0);
    check("rst_dout", s2_dout, 8'h00);
    check("rst1_cs",  s1_cs,   1'b1);
    check("rst1_dout", s1_dout, 8'h00);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);

    // Reset mid-transfer aborts at once with no done
    s2_byte = 8'hC3;
    @(negedge clk);
    s2_din   = 8'h3C;
    s2_start = 1'b1;
    @(posedge clk); #1;
    s2_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_busy_before", s2_buzy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("abort_cs",   s2_cs,   1'b1);
    check("abort_sclk", s2_sclk, 1'b0);
    check("abort_mosi", s2_mosi, 1'b0);
    check("abort_buzy", s2_buzy, 1'b0);
    check("abort_done", s2_done, 1'b0);
    @(negedge clk) reset = 1'b1;
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (s2_done) dn++;
    end
    check("abort_no_done", dn, 0);

    // All-zero tx, slave returns 8e
    run_byte2(8'h00, 8'h8e, 1'b0, 1'b0, lat, cs_low, mbits, ndone);
    check("z_latency", lat, 32);
    check("z_cs_low",  cs_low, CS_LOW_1B);
    check("z_mosi",    mbits, 8'h00);
    check("z_ndone",   ndone, 1);

    // Loopback A5
    run_byte2(8'hA5, 8'h00, 1'b1, 1'b0, lat, cs_low, mbits, ndone);
    check("lb_latency", lat, 32);
    check("lb_mosi",    mbits, 8'hA5);
    check("lb_ndone",   ndone, 1);

    // Start while busy ignored; data_in change after acceptance harmless
    run_byte2(8'h96, 8'h69, 1'b0, 1'b1, lat, cs_low, mbits, ndone);
    check("busy_latency", lat, 32);
    check("busy_mosi",    mbits, 8'h96);
    check("busy_ndone",   ndone, 1);
    check("busy_idle_after", s2_buzy, 1'b0);

    // Start held high: back-to-back bytes
    s2_byte = 8'h33;
    s2_loop = 1'b0;
    repeat (3) exp_q.push_back(8'h33);
    @(negedge clk);
    s2_din   = 8'h5A;
    s2_start = 1'b1;
    dn = 0; bad_gap = 0;
    for (k = 0; k < 300 && dn < 3; k++) begin
      @(posedge clk); #1;
      if (!s2_buzy && s2_sclk) bad_gap++;
      if (s2_done) begin
        held_k[dn] = k;
        dn++;
        sb_pop_check("held_dout", s2_dout);
        if (dn == 3) s2_start = 1'b0;
      end
    end
    s2_start = 1'b0;
    check("held_ndone", dn, 3);
    check("held_gap01", held_k[1] - held_k[0], HELD_GAP);
    check("held_gap12", held_k[2] - held_k[1], HELD_GAP);
    check("held_sclk_low_in_gap", bad_gap, 0);
    repeat (40) @(posedge clk);
    #1;
    check("held_stopped", s2_buzy, 1'b0);

    // CLK_DIV=1: 48 bytes, start re-issued on each done
    dn = 0; issued = 0; frames = 0; last_k = -1; hold = 0;
    prev_cs = s1_cs;
    @(posedge clk); #1;
    rb = 8'($urandom);
    s1_byte = rb; s1_din = 8'($urandom); exp_q.push_back(rb);
    s1_start = 1'b1; hold = 2; issued = 1;
    for (k = 0; k < 2000 && dn < 48; k++) begin
      @(posedge clk); #1;
      if (hold > 0) begin
        hold--;
        if (hold == 0) s1_start = 1'b0;
      end
      if (prev_cs && !s1_cs) frames++;
      prev_cs = s1_cs;
      if (s1_done) begin
        dn++;
        sb_pop_check("d1_dout", s1_dout);
        if (last_k >= 0) check("d1_interval", k - last_k, D1_GAP);
        last_k = k;
        if (issued < 48) begin
          rb = 8'($urandom);
          s1_byte = rb; s1_din = 8'($urandom); exp_q.push_back(rb);
          s1_start = 1'b1; hold = 2; issued++;
        end
      end
    end
    check("d1_ndone",  dn, 48);
    check("d1_frames", frames, D1_FRAMES);
    repeat (30) @(posedge clk);
    #1;
    check("d1_idle_after", s1_buzy, 1'b0);
    check("d1_cs_after",   s1_cs,   1'b1);
    check("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_spi_byte_master
